donut_ray_sequencer: RTL and testbench
======================================

Name: donut_ray_sequencer

Overview:
- Initiator for the donut ray-march hit-test core: generates one ray per pixel in raster order and pulses `start`.
- Waits a fixed number of march clocks, then samples `hit`/`light` from the core.
- Converts the sample to an 8-bit shade and offers it downstream with a valid/ready handshake.
- Sits between the frame controller (`frame_start`) and the pixel/line buffer; camera origin, light vector and ray deltas are supplied by the camera/rotation logic.

Parameters:
- STEPS, 8, march clocks between `start` and sampling (core needs 8).
- COLS, 160, rays per row.
- ROWS, 120, rows per frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse; (re)starts a frame at row 0, col 0
- rx0  in  16  signed ray x-direction at col 0 of each row
- ry0  in  16  signed ray y-direction for row 0
- rz0  in  16  signed ray z-direction, constant for the frame
- dxh  in  16  signed rx increment per column
- dyv  in  16  signed ry increment per row
- start  out  1  to core: latch inputs and begin march
- rx, ry, rz  out  16 each  signed ray direction to core, stable from `start` until sample
- hit  in  1  from core
- light  in  16  signed light value from core, 1.0 = 256
- shade_valid  out  1  result available
- shade_ready  in  1  downstream accepts result
- shade  out  8  pixel intensity
- shade_col  out  8  column of result
- shade_row  out  7  row of result
- frame_done  out  1  one-cycle pulse after the last ray of the frame is accepted

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; start=0, shade_valid=0, shade=0, shade_col=0, shade_row=0, frame_done=0; rx=ry=rz=0.
- States: IDLE, LAUNCH, MARCH, SAMPLE, OFFER.
- IDLE: wait for `frame_start`. On `frame_start`: col=0, row=0, rx=rx0, ry=ry0, rz=rz0, then go to LAUNCH.
- LAUNCH: start=1 for exactly this cycle (cycle S); step counter cleared; go to MARCH.
- MARCH: start=0; step counter increments each cycle over cycles S+1..S+STEPS; after the STEPS-th cycle, go to SAMPLE.
- SAMPLE (cycle S+STEPS+1): register `hit` and `light`.
  - Shade: hit ? clamp(light, 0, 255) : background, where clamp gives light<0 -> 0 and light>255 -> 255.
  - Latch shade_col=col, shade_row=row.
  - Set shade_valid=1; go to OFFER.
- OFFER: hold shade, shade_col, shade_row and shade_valid stable until shade_valid && shade_ready. On the accepting edge:
  - shade_valid=0.
  - If col<COLS-1: col+=1, rx+=dxh; go to LAUNCH.
  - Else if row<ROWS-1: col=0, row+=1, rx=rx0, ry+=dyv; go to LAUNCH.
  - Else: frame_done=1 for one cycle; go to IDLE.
- Throughput: STEPS+3 clocks per ray when shade_ready is held high.
- Arithmetic: 16-bit two's complement, wraps with no saturation. rx0/ry0/rz0 are sampled only at `frame_start`; dxh/dyv are sampled at each increment.
- `frame_start` in any non-IDLE state: abort the current ray, drop shade_valid the next cycle without a handshake (result discarded), restart at row 0, col 0 with newly sampled inputs, go to LAUNCH.
- `frame_start` in the same cycle as an OFFER accept: `frame_start` wins; no increment, no frame_done.
- rx/ry/rz change only on the accept edge or at `frame_start`, never during MARCH.
- Mid-operation reset returns to IDLE with all outputs at reset values.

Optional Feature:
- Macro: DONUT_SEQ_BG_GRADIENT_EN.
- Defined: on a miss, background = {row[5:0], 2'b00} (vertical gradient).
- Undefined: on a miss, background = 0.
- Hit shading is identical in both builds.

Test Plan:
- Reset, then `frame_start` with rx0=0x0100, dxh=0x0010, shade_ready=1 -> start pulses every 11 clocks; rx at the 3rd start = 0x0120; shade_col sequence 0,1,2.
- Core model returns hit=1, light=0x0180 -> shade=255; light=0xFF00 -> shade=0; light=0x0040 -> shade=64.
- Hold shade_ready=0 for 20 clocks in OFFER -> shade/shade_col stable, no new start; after shade_ready=1 -> next start 1 clock after accept.
- COLS=4, ROWS=2, ry0=0, dyv=0x0008 -> after col 3 row 0: rx=rx0, ry=0x0008, shade_row=1; after the 8th accept -> frame_done pulses once, state IDLE.
- `frame_start` during MARCH of ray (col 2, row 0) -> no shade for that ray; next start carries rx=rx0, shade_col=0.
- Miss at row 5 -> shade=0 (macro off) / shade=20 (DONUT_SEQ_BG_GRADIENT_EN on).

Source files
------------

// File: rtl/donut_ray_sequencer.sv
// donut_ray_sequencer: raster-order ray initiator for the donut ray-march core; launches a ray,
// waits STEPS march clocks, converts hit/light to an 8-bit shade and offers it on valid/ready.
// Optional build macro DONUT_SEQ_BG_GRADIENT_EN: misses shade as a vertical gradient {row[5:0],2'b00}
// instead of black.
module donut_ray_sequencer #(
    parameter int STEPS = 8,
    parameter int COLS  = 160,
    parameter int ROWS  = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [15:0] rx0,
    input  logic [15:0] ry0,
    input  logic [15:0] rz0,
    input  logic [15:0] dxh,
    input  logic [15:0] dyv,
    output logic        start,
    output logic [15:0] rx,
    output logic [15:0] ry,
    output logic [15:0] rz,
    input  logic        hit,
    input  logic [15:0] light,
    output logic        shade_valid,
    input  logic        shade_ready,
    output logic [7:0]  shade,
    output logic [7:0]  shade_col,
    output logic [6:0]  shade_row,
    output logic        frame_done
);
    typedef enum logic [2:0] {IDLE, LAUNCH, MARCH, SAMPLE, OFFER} state_t;

    localparam int SW = $clog2(STEPS + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);
    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [7:0]    col_q, col_d;
    logic [6:0]    row_q, row_d;
    logic [15:0]   rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic [15:0]   rx0_q, rx0_d;
    logic          start_q, start_d;
    logic          valid_q, valid_d;
    logic [7:0]    shade_q, shade_d;
    logic [7:0]    shade_col_q, shade_col_d;
    logic [6:0]    shade_row_q, shade_row_d;
    logic          done_q, done_d;
    logic [7:0]    lit, bg;

    // Shade sources: light clamped to 0..255 for hits, background colour for misses
    always_comb begin
        lit = light[15] ? 8'd0 : (|light[14:8]) ? 8'd255 : light[7:0];
`ifdef DONUT_SEQ_BG_GRADIENT_EN
        bg = {row_q[5:0], 2'b00};
`else
        bg = 8'd0;
`endif
    end

    // Next-state logic; frame_start overrides everything, including a same-cycle accept
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        col_d       = col_q;
        row_d       = row_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        rz_d        = rz_q;
        rx0_d       = rx0_q;
        start_d     = 1'b0;
        valid_d     = valid_q;
        shade_d     = shade_q;
        shade_col_d = shade_col_q;
        shade_row_d = shade_row_q;
        done_d      = 1'b0;
        if (frame_start) begin
            col_d   = 8'd0;
            row_d   = 7'd0;
            rx_d    = rx0;
            rx0_d   = rx0;
            ry_d    = ry0;
            rz_d    = rz0;
            valid_d = 1'b0;
            start_d = 1'b1;
            state_d = LAUNCH;
        end else begin
            case (state_q)
                LAUNCH: begin
                    step_d  = '0;
                    state_d = MARCH;
                end
                MARCH: begin
                    step_d  = step_q + 1'b1;
                    state_d = (step_q == STEP_LAST) ? SAMPLE : MARCH;
                end
                SAMPLE: begin
                    shade_d     = hit ? lit : bg;
                    shade_col_d = col_q;
                    shade_row_d = row_q;
                    valid_d     = 1'b1;
                    state_d     = OFFER;
                end
                OFFER: begin
                    if (shade_ready) begin
                        valid_d = 1'b0;
                        if (col_q < COL_LAST) begin
                            col_d   = col_q + 8'd1;
                            rx_d    = rx_q + dxh;
                            start_d = 1'b1;
                            state_d = LAUNCH;
                        end else if (row_q < ROW_LAST) begin
                            col_d   = 8'd0;
                            row_d   = row_q + 7'd1;
                            rx_d    = rx0_q;
                            ry_d    = ry_q + dyv;
                            start_d = 1'b1;
                            state_d = LAUNCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            col_q       <= 8'd0;
            row_q       <= 7'd0;
            rx_q        <= 16'd0;
            ry_q        <= 16'd0;
            rz_q        <= 16'd0;
            rx0_q       <= 16'd0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            shade_q     <= 8'd0;
            shade_col_q <= 8'd0;
            shade_row_q <= 7'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            rz_q        <= rz_d;
            rx0_q       <= rx0_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            shade_q     <= shade_d;
            shade_col_q <= shade_col_d;
            shade_row_q <= shade_row_d;
            done_q      <= done_d;
        end
    end

    assign start       = start_q;
    assign rx          = rx_q;
    assign ry          = ry_q;
    assign rz          = rz_q;
    assign shade_valid = valid_q;
    assign shade       = shade_q;
    assign shade_col   = shade_col_q;
    assign shade_row   = shade_row_q;
    assign frame_done  = done_q;
endmodule

// File: tb/tb_donut_ray_sequencer.sv
// tb_donut_ray_sequencer: directed self-checking bench for donut_ray_sequencer (STEPS=8, COLS=4, ROWS=8).
module tb_donut_ray_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] rx0 = '0, ry0 = '0, rz0 = '0, dxh = '0, dyv = '0;
    logic        start;
    logic [15:0] rx, ry, rz;
    logic        hit = 1'b0;
    logic [15:0] light = '0;
    logic        shade_valid;
    logic        shade_ready = 1'b0;
    logic [7:0]  shade, shade_col;
    logic [6:0]  shade_row;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int s1, s2, s3, bad;

    donut_ray_sequencer #(.STEPS(8), .COLS(4), .ROWS(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .rx0(rx0), .ry0(ry0), .rz0(rz0), .dxh(dxh), .dyv(dyv),
        .start(start), .rx(rx), .ry(ry), .rz(rz),
        .hit(hit), .light(light),
        .shade_valid(shade_valid), .shade_ready(shade_ready),
        .shade(shade), .shade_col(shade_col), .shade_row(shade_row),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bg(input int row);
`ifdef DONUT_SEQ_BG_GRADIENT_EN
        return 8'(row * 4);
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        do begin @(negedge clk); n++; end while (!start && n < 40);
        chk("start_timeout", start, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!shade_valid && n < 40);
        chk("valid_timeout", shade_valid, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_valid", shade_valid, 0);
        chk("rst_shade", {shade, shade_col, 1'b0, shade_row}, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ray", {rx, ry}, 0);
        chk("rst_rz", rz, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", start, 0);

        rx0 = 16'h0100; ry0 = 16'h0000; rz0 = 16'h0300; dxh = 16'h0010; dyv = 16'h0008;
        shade_ready = 1'b1; hit = 1'b1; light = 16'h0180;
        pulse_fs();
        s1 = cyc;
        chk("start1", start, 1);
        chk("rx1", rx, 16'h0100);
        chk("ry1", ry, 16'h0000);
        chk("rz1", rz, 16'h0300);
        wait_valid();
        chk("shade_clamp_hi", shade, 255);
        chk("col0", shade_col, 0);
        chk("row0", shade_row, 0);
        light = 16'hFF00;
        wait_start();
        s2 = cyc;
        chk("period12", s2 - s1, 11);
        chk("rx2", rx, 16'h0110);
        wait_valid();
        chk("shade_clamp_lo", shade, 0);
        chk("col1", shade_col, 1);
        light = 16'h0040;
        wait_start();
        s3 = cyc;
        chk("period23", s3 - s2, 11);
        chk("rx3", rx, 16'h0120);
        shade_ready = 1'b0;
        wait_valid();
        chk("shade_mid", shade, 64);
        chk("col2", shade_col, 2);

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!shade_valid || shade !== 8'd64 || shade_col !== 8'd2 || start) bad++;
        end
        chk("hold_stable", bad, 0);
        shade_ready = 1'b1;
        hit = 1'b0;
        @(negedge clk);
        chk("start_after_accept", start, 1);
        chk("valid_dropped", shade_valid, 0);
        chk("rx4", rx, 16'h0130);
        wait_valid();
        chk("miss_row0", shade, 0);
        chk("col3", shade_col, 3);
        wait_start();
        chk("rx_row_wrap", rx, 16'h0100);
        chk("ry_row1", ry, 16'h0008);
        wait_valid();
        chk("row1", shade_row, 1);
        chk("row1_col0", shade_col, 0);
        chk("miss_row1", shade, bg(1));

        for (int k = 0; k < 27; k++) begin
            wait_valid();
            if (shade_row == 7'd5 && shade_col == 8'd0) chk("miss_row5", shade, bg(5));
        end
        chk("last_row", shade_row, 7);
        chk("last_col", shade_col, 3);
        @(negedge clk);
        chk("frame_done_hi", frame_done, 1);
        chk("frame_done_nostart", start, 0);
        @(negedge clk);
        chk("frame_done_lo", frame_done, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (start || shade_valid || frame_done) bad++;
        end
        chk("idle_after_frame", bad, 0);

        rx0 = 16'h0200; ry0 = 16'h0010; hit = 1'b1; light = 16'h0050;
        pulse_fs();
        chk("f2_start", start, 1);
        wait_valid();
        wait_valid();
        chk("f2_col1", shade_col, 1);
        chk("f2_shade", shade, 8'h50);
        wait_start();
        chk("f2_rx_col2", rx, 16'h0220);
        repeat (3) @(negedge clk);
        rx0 = 16'h0250;
        pulse_fs();
        chk("abort_start", start, 1);
        chk("abort_rx", rx, 16'h0250);
        chk("abort_ry", ry, 16'h0010);
        chk("abort_valid", shade_valid, 0);
        shade_ready = 1'b0;
        wait_valid();
        chk("abort_col", shade_col, 0);
        chk("abort_row", shade_row, 0);

        rx0 = 16'h0300;
        pulse_fs();
        chk("offer_abort_valid", shade_valid, 0);
        chk("offer_abort_start", start, 1);
        chk("offer_abort_rx", rx, 16'h0300);
        wait_valid();
        rx0 = 16'h0400;
        shade_ready = 1'b1;
        pulse_fs();
        chk("fs_win_start", start, 1);
        chk("fs_win_valid", shade_valid, 0);
        chk("fs_win_done", frame_done, 0);
        chk("fs_win_rx", rx, 16'h0400);
        wait_valid();
        chk("fs_win_col", shade_col, 0);
        chk("fs_win_row", shade_row, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
